// File: rtl/sram_fifo_pkg.sv
// Shared defaults and types for the SRAM-backed FIFO controller.
package sram_fifo_pkg;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 8;
  localparam int OBUF_DEPTH     = 2;

  typedef logic [DEF_ADDR_WIDTH-1:0] ptr_t;
  typedef logic [DEF_DATA_WIDTH-1:0] word_t;
endpackage

// File: rtl/sram_fifo_obuf.sv
// Two-entry registered FIFO that holds words returned by the SRAM read port.
module sram_fifo_obuf import sram_fifo_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cap_valid,
  input  logic [DATA_WIDTH-1:0] cap_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [1:0]            count
);
  logic [DATA_WIDTH-1:0] mem [OBUF_DEPTH];
  logic                  hd;
  logic                  tl;
  logic                  pop;

  assign out_valid = (count != 2'd0);
  assign out_data  = mem[hd];
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      hd    <= 1'b0;
      tl    <= 1'b0;
      count <= 2'd0;
    end else begin
      if (cap_valid) tl <= ~tl;
      if (pop)       hd <= ~hd;
      count <= count + 2'(cap_valid) - 2'(pop);
    end
  end

  // Data storage needs no reset; count gates visibility.
  always_ff @(posedge clk) begin
    if (cap_valid) mem[tl] <= cap_data;
  end
endmodule

// File: rtl/sram_fifo_ctrl.sv
// FIFO controller driving a 1W/1R SRAM macro plus a 2-entry output buffer.
// Optional occupancy/almost-full outputs are enabled by SRAM_FIFO_LEVEL_EN.
module sram_fifo_ctrl import sram_fifo_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int RAM_DEPTH  = 1 << ADDR_WIDTH
`ifdef SRAM_FIFO_LEVEL_EN
  , parameter int AFULL_THRESH = RAM_DEPTH - 4
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_valid,
  output logic                  push_ready,
  input  logic [DATA_WIDTH-1:0] push_data,
  output logic                  pop_valid,
  input  logic                  pop_ready,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic                  sram_csb0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  output logic                  sram_csb1,
  output logic [ADDR_WIDTH-1:0] sram_addr1,
  input  logic [DATA_WIDTH-1:0] sram_dout1,
  output logic                  empty
`ifdef SRAM_FIFO_LEVEL_EN
  , output logic [ADDR_WIDTH+1:0] level
  , output logic                  almost_full
`endif
);
  localparam int CW = ADDR_WIDTH + 1;

  logic [ADDR_WIDTH-1:0] wptr;
  logic [ADDR_WIDTH-1:0] rptr;
  logic [CW-1:0]         sram_cnt;
  logic                  rd_inflight;
  logic [1:0]            obuf_cnt;
  logic                  push_fire;
  logic                  pop_fire;
  logic                  rd_issue;
  logic [2:0]            obuf_need;

  assign push_ready = !rst && (sram_cnt < CW'(RAM_DEPTH));
  assign push_fire  = push_valid && push_ready;
  assign pop_fire   = pop_valid && pop_ready;

  assign sram_csb0  = !push_fire;
  assign sram_addr0 = wptr;
  assign sram_din0  = push_data;

  // Slots the buffer will hold after this edge; pop_fire implies obuf_cnt >= 1.
  assign obuf_need  = {1'b0, obuf_cnt} + {2'b0, rd_inflight} - {2'b0, pop_fire};
  assign rd_issue   = !rst && (sram_cnt != '0) && (obuf_need < 3'(OBUF_DEPTH));

  assign sram_csb1  = !rd_issue;
  assign sram_addr1 = rptr;

  assign empty = (sram_cnt == '0) && !rd_inflight && (obuf_cnt == 2'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr        <= '0;
      rptr        <= '0;
      sram_cnt    <= '0;
      rd_inflight <= 1'b0;
    end else begin
      if (push_fire)
        wptr <= (wptr == ADDR_WIDTH'(RAM_DEPTH - 1)) ? '0 : wptr + 1'b1;
      if (rd_issue)
        rptr <= (rptr == ADDR_WIDTH'(RAM_DEPTH - 1)) ? '0 : rptr + 1'b1;
      sram_cnt    <= sram_cnt + CW'(push_fire) - CW'(rd_issue);
      rd_inflight <= rd_issue;
    end
  end

  sram_fifo_obuf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_obuf (
    .clk       (clk),
    .rst       (rst),
    .cap_valid (rd_inflight),
    .cap_data  (sram_dout1),
    .out_valid (pop_valid),
    .out_ready (pop_ready),
    .out_data  (pop_data),
    .count     (obuf_cnt)
  );

`ifdef SRAM_FIFO_LEVEL_EN
  localparam int LW = ADDR_WIDTH + 2;

  // Tracks sram_cnt + rd_inflight + obuf_cnt via net push/pop deltas.
  always_ff @(posedge clk) begin
    if (rst) level <= '0;
    else     level <= level + LW'(push_fire) - LW'(pop_fire);
  end

  assign almost_full = (sram_cnt >= CW'(AFULL_THRESH));
`endif
endmodule
